// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a WIDTH-bit AND/OR/ADD/SUB/SLT operation on a shared 4-bit alu by
// issuing one nibble per cycle, LSB first. The alu carry-out of each nibble
// is chained into the carry-in of the next nibble.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start, op, a, b,    request handshake; operands and op are latched when
//   cin                 start is accepted in IDLE
//   busy, done, err     status: busy while not IDLE, one-cycle done pulse,
//                       err flags an illegal op (valid with done)
//   result, cout, slt,  final outputs, held until the next accepted start
//   zero
//   alu_a, alu_b,       drive the external alu (0 when not running)
//   alu_ci, alu_op
//   alu_r, alu_co       combinational alu response
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             slt,
  output logic             zero,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_ci,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_r,
  input  logic             alu_co
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;

  logic [CW-1:0]    cnt_n;
  logic             last;
  logic             chain;
  logic             legal;
  logic             ovf;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  function automatic logic first_ci(input logic [2:0] o, input logic c);
    case (o)
      OP_ADD:         first_ci = c;
      OP_SUB, OP_SLT: first_ci = 1'b1;
      default:        first_ci = 1'b0;
    endcase
  endfunction

  always_comb begin
    cnt_n = cnt + 1'b1;
    last  = (cnt == CW'(NIB - 1));
    // Nibbles above cnt are still zero (cleared on accept), so OR-ing the
    // shifted alu nibble in is equivalent to a part-select write.
    res_next = result | ({{(WIDTH-4){1'b0}}, alu_r} << {cnt, 2'b00});
    a_nxt    = a_q >> {cnt_n, 2'b00};
    b_nxt    = b_q >> {cnt_n, 2'b00};
    chain    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    legal    = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    // Signed overflow of a - b, evaluated on the final (MSB) nibble.
    ovf      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[3] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      slt    <= 1'b0;
      zero   <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_ci <= 1'b0;
      alu_op <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            slt    <= 1'b0;
            zero   <= 1'b0;
            busy   <= 1'b1;
            if (legal) begin
              state  <= RUN;
              // alu inputs are registered, so the first nibble is presented
              // straight from the incoming operands.
              alu_a  <= a[3:0];
              alu_b  <= b[3:0];
              alu_ci <= first_ci(op, cin);
              alu_op <= (op == OP_SLT) ? OP_SUB : op;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end

        RUN: begin
          result <= res_next;
          if (last) begin
            state  <= DONE;
            done   <= 1'b1;
            cout   <= chain ? alu_co : 1'b0;
            zero   <= (res_next == '0);
            slt    <= (op_q == OP_SLT) ? (alu_r[3] ^ ovf) : 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_ci <= 1'b0;
            alu_op <= '0;
          end else begin
            cnt    <= cnt_n;
            alu_a  <= a_nxt[3:0];
            alu_b  <= b_nxt[3:0];
            alu_ci <= chain ? alu_co : 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer (WIDTH=16) with a behavioural 4-bit alu
// attached. Directed table vectors, corner-case sequences and random
// operations compared against a whole-word arithmetic reference model.
module tb_alu_nibble_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic          cout;
  logic          slt;
  logic          zero;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic          alu_ci;
  logic [2:0]    alu_op;
  logic [3:0]    alu_r;
  logic          alu_co;

  int n_checks = 0;
  int n_fail   = 0;

  alu_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .err(err), .result(result), .cout(cout),
    .slt(slt), .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_op(alu_op), .alu_r(alu_r), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  // Shared 4-bit alu
  always_comb begin
    logic [4:0] s;
    s      = '0;
    alu_r  = '0;
    alu_co = 1'b0;
    case (alu_op)
      3'd0: alu_r = alu_a & alu_b;
      3'd1: alu_r = alu_a | alu_b;
      3'd2: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci};
        alu_r = s[3:0]; alu_co = s[4];
      end
      3'd6: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_ci};
        alu_r = s[3:0]; alu_co = s[4];
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference model
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output logic [W-1:0] r, output logic co,
                       output logic sl, output logic z, output logic e);
    logic [W:0] s;
    r = '0; co = 1'b0; sl = 1'b0; e = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin s = {1'b0, x} + {1'b0, y} + (W+1)'(c); r = s[W-1:0]; co = s[W]; end
      3'd6, 3'd7: begin
        r  = x - y;
        co = (x >= y);
        sl = (o == 3'd7) ? ($signed(x) < $signed(y)) : 1'b0;
      end
      default: e = 1'b1;
    endcase
    z = (r == '0) && !e;
  endtask

  // Issue one request; returns edges from the accepting edge to done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, output int lat, output logic ok, output logic busy0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cin = c;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    busy0 = busy;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ok = done;
  endtask

  task automatic verify(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c, input logic [W-1:0] er,
                        input logic eco, input logic esl, input logic ez, input logic ee);
    int lat; logic ok; logic busy0; logic [W-1:0] held;
    run_op(o, x, y, c, lat, ok, busy0);
    check({tag, ".done_seen"}, 32'(ok), 32'd1);
    check({tag, ".busy"}, 32'(busy0), 32'd1);
    check({tag, ".latency"}, 32'(lat), ee ? 32'd0 : 32'(NIB));
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".err"}, 32'(err), 32'(ee));
    check({tag, ".cout"}, 32'(cout), 32'(eco));
    check({tag, ".slt"}, 32'(slt), 32'(esl));
    if (!ee) check({tag, ".zero"}, 32'(zero), 32'(ez));
    check({tag, ".alu_idle"}, {21'd0, alu_a, alu_b, alu_ci, alu_op}, 32'd0);
    held = result;
    @(negedge clk);
    check({tag, ".done_pulse"}, {30'd0, done, busy}, 32'd0);
    check({tag, ".held"}, 32'(result), 32'(held));
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] r;
    logic         co;
    logic         sl;
    logic         z;
    logic         e;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int lat; logic ok; logic busy0; int dseen;
    logic [W-1:0] er; logic eco, esl, ez, ee;
    logic [2:0] ro; logic [W-1:0] ra, rb; logic rc;

    tbl[0]  = '{3'd2, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3'd6, 16'h0005, 16'h0002, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'd6, 16'h0002, 16'h0004, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd7, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{3'd7, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'd7, 16'hFFFC, 16'hFFFC, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{3'd0, 16'h0F0F, 16'h00FF, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'd1, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd4, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{3'd2, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'd2, 16'h8FFF, 16'h7001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("reset.outputs", {23'd0, busy, done, err, cout, slt, zero, 3'd0}, 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.alu", {21'd0, alu_a, alu_b, alu_ci, alu_op}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      verify($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].r, tbl[i].co, tbl[i].sl, tbl[i].z, tbl[i].e);

    // start pulsed while running must not disturb the active request
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = 3'd0; a = 16'h0000; b = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("midrun.latency", 32'(lat), 32'(NIB));
    check("midrun.result", 32'(result), 32'h3333);
    @(negedge clk);
    check("midrun.no_requeue", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check("midrun.idle", 32'(busy), 32'd0);

    // reset with cnt == 2 aborts and discards the partial result
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 16'h4444; b = 16'h1111;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.partial_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort.result", 32'(result), 32'd0);
    check("abort.flags", {23'd0, busy, done, err, cout, slt, zero, 3'd0}, 32'd0);
    check("abort.alu", {21'd0, alu_a, alu_b, alu_ci, alu_op}, 32'd0);
    dseen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      if (done) dseen++;
    end
    check("abort.no_done", 32'(dseen), 32'd0);
    verify("after_abort", 3'd2, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);

    // random requests against the word-level model
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = (n % 5 == 0) ? ra : W'($urandom);
      rc = 1'($urandom);
      model(ro, ra, rb, rc, er, eco, esl, ez, ee);
      verify($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, rc, er, eco, esl, ez, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
